// File: rtl/busca_instrucao_pkg.sv
// busca_pkg: shared types and widths for the fetch stage.
// Fetch-state encoding and the PC increment helper.
package busca_pkg;

  localparam int LARGURA_END   = 8;
  localparam int LARGURA_INSTR = 32;
  localparam int LARGURA_CONT  = 16;

  typedef enum logic [1:0] {
    INICIO,
    BUSCA,
    ESPERA,
    SEGURA
  } estado_t;

  function automatic logic [LARGURA_END-1:0] pc_mais_um(
    input logic [LARGURA_END-1:0] pc
  );
    return pc + LARGURA_END'(1);
  endfunction

endpackage

// File: rtl/busca_instrucao_if.sv
// busca_instrucao_if: memory read port and decoder handshake.
// master = fetch stage, slave = memory/decoder side.
interface busca_instrucao_if;
  import busca_pkg::*;

  logic                     mem_leitura;
  logic [LARGURA_END-1:0]   mem_endereco;
  logic [LARGURA_INSTR-1:0] mem_dado;
  logic [LARGURA_INSTR-1:0] instrucao;
  logic [LARGURA_END-1:0]   pc_instrucao;
  logic                     instrucao_valida;
  logic                     decod_pronto;

  modport master (
    output mem_leitura,
    output mem_endereco,
    input  mem_dado,
    output instrucao,
    output pc_instrucao,
    output instrucao_valida,
    input  decod_pronto
  );

  modport slave (
    input  mem_leitura,
    input  mem_endereco,
    output mem_dado,
    input  instrucao,
    input  pc_instrucao,
    input  instrucao_valida,
    output decod_pronto
  );

endinterface

// File: rtl/busca_instrucao_contador.sv
// contador_saturante: 16-bit event counter that sticks at all-ones.
// Used by the optional fetch performance counters.
module contador_saturante
  import busca_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  output logic [LARGURA_CONT-1:0] o_valor
);

  // count enabled cycles, hold once saturated
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valor <= '0;
    end else if (i_en && (o_valor != '1)) begin
      o_valor <= o_valor + LARGURA_CONT'(1);
    end
  end

endmodule

// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction fetch stage with branch redirect.
// Optional BUSCA_PERF_EN adds transfer/bubble counters.
module busca_instrucao
  import busca_pkg::*;
#(
  parameter logic [LARGURA_END-1:0] VETOR_RESET = '0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [LARGURA_END-1:0]  valorPC,
  output logic                    EscrevePC,
  output logic [LARGURA_END-1:0]  valorEntradaPC,
  input  logic                    desvio,
  input  logic [LARGURA_END-1:0]  alvo_desvio,
`ifdef BUSCA_PERF_EN
  output logic [LARGURA_CONT-1:0] cont_instrucoes,
  output logic [LARGURA_CONT-1:0] cont_bolhas,
`endif
  busca_instrucao_if.master       bus
);

  estado_t r_estado;
  estado_t w_prox;

  logic                     w_transf;
  logic [LARGURA_END-1:0]   w_pc_prox;

  logic                     r_mem_leitura;
  logic [LARGURA_END-1:0]   r_mem_endereco;
  logic [LARGURA_INSTR-1:0] r_instrucao;
  logic [LARGURA_END-1:0]   r_pc_instrucao;
  logic                     r_valida;

  assign w_transf = r_valida && bus.decod_pronto;

  // next state and PC write port; redirect overrides all but INICIO
  always_comb begin
    w_prox         = r_estado;
    EscrevePC      = 1'b0;
    valorEntradaPC = VETOR_RESET;
    unique case (r_estado)
      INICIO: begin
        EscrevePC = 1'b1;
        w_prox    = BUSCA;
      end
      BUSCA: begin
        w_prox = ESPERA;
      end
      ESPERA: begin
        EscrevePC      = 1'b1;
        valorEntradaPC = pc_mais_um(valorPC);
        w_prox         = SEGURA;
      end
      SEGURA: begin
        if (w_transf) w_prox = BUSCA;
      end
      default: w_prox = INICIO;
    endcase
    if (desvio && (r_estado != INICIO)) begin
      EscrevePC      = 1'b1;
      valorEntradaPC = alvo_desvio;
      w_prox         = BUSCA;
    end
  end

  // address of the next read: the value PC will hold after this edge
  assign w_pc_prox = EscrevePC ? valorEntradaPC : valorPC;

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_estado <= INICIO;
    else          r_estado <= w_prox;
  end

  // registered memory strobe, held word and handshake valid
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_leitura  <= 1'b0;
      r_mem_endereco <= '0;
      r_instrucao    <= '0;
      r_pc_instrucao <= '0;
      r_valida       <= 1'b0;
    end else begin
      r_mem_leitura <= (w_prox == BUSCA);
      if (w_prox == BUSCA) r_mem_endereco <= w_pc_prox;
      if ((r_estado == ESPERA) && !desvio) begin
        r_instrucao    <= bus.mem_dado;
        r_pc_instrucao <= r_mem_endereco;
      end
      r_valida <= (w_prox == SEGURA);
    end
  end

  assign bus.mem_leitura      = r_mem_leitura;
  assign bus.mem_endereco     = r_mem_endereco;
  assign bus.instrucao        = r_instrucao;
  assign bus.pc_instrucao     = r_pc_instrucao;
  assign bus.instrucao_valida = r_valida;

`ifdef BUSCA_PERF_EN
  logic w_bolha;

  assign w_bolha = r_valida && !bus.decod_pronto;

  contador_saturante u_cont_instr (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_en    (w_transf),
    .o_valor (cont_instrucoes)
  );

  contador_saturante u_cont_bolhas (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_en    (w_bolha),
    .o_valor (cont_bolhas)
  );
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao: directed + random checks of the fetch stage.
// Scoreboard tracks the expected instruction stream per transfer.
module tb_busca_instrucao;
  import busca_pkg::*;

  localparam logic [7:0] VR = 8'h00;

  logic       clock;
  logic       reset_n;
  logic [7:0] valorPC;
  logic       EscrevePC;
  logic [7:0] valorEntradaPC;
  logic       desvio;
  logic [7:0] alvo_desvio;
`ifdef BUSCA_PERF_EN
  logic [15:0] cont_instrucoes;
  logic [15:0] cont_bolhas;
`endif

  busca_instrucao_if bus ();

  busca_instrucao #(.VETOR_RESET(VR)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .valorPC        (valorPC),
    .EscrevePC      (EscrevePC),
    .valorEntradaPC (valorEntradaPC),
    .desvio         (desvio),
    .alvo_desvio    (alvo_desvio),
`ifdef BUSCA_PERF_EN
    .cont_instrucoes(cont_instrucoes),
    .cont_bolhas    (cont_bolhas),
`endif
    .bus            (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_xfer = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] palavra(input logic [7:0] a);
    return 32'hA000_0000 + {24'h0, a};
  endfunction

  // ProgramCounter model
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)       valorPC <= 8'h00;
    else if (EscrevePC) valorPC <= valorEntradaPC;
  end

  // synchronous instruction memory: word n = A000_0000 + n
  always @(posedge clock) begin
    if (bus.mem_leitura) bus.mem_dado <= palavra(bus.mem_endereco);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.instrucao_valida && n < 20);
    if (!bus.instrucao_valida) chk("valid_timeout", 32'(n), 32'd0);
  endtask

  // scoreboard: next expected transfer address
  logic [7:0]  exp_q[$];
  logic        armed = 1'b0;
  logic        p_hold = 1'b0;
  logic [31:0] p_instr;
  logic [7:0]  p_pc;
  logic [15:0] m_instr = 0;
  logic [15:0] m_bolhas = 0;

  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      armed    = 1'b0;
      p_hold   = 1'b0;
      m_instr  = 0;
      m_bolhas = 0;
    end else begin
      if (!armed) begin
        exp_q.push_back(VR);
        armed = 1'b1;
      end
      if (p_hold) begin
        chk("hold_valid", 32'(bus.instrucao_valida), 32'd1);
        chk("hold_instr", bus.instrucao, p_instr);
        chk("hold_pc", 32'(bus.pc_instrucao), 32'(p_pc));
        chk("hold_noread", 32'(bus.mem_leitura), 32'd0);
      end
      if (bus.instrucao_valida && bus.decod_pronto) begin
        logic [7:0] e;
        n_xfer++;
        if (m_instr != 16'hFFFF) m_instr = m_instr + 1;
        chk("sb_depth", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_pc", 32'(bus.pc_instrucao), 32'(e));
          chk("sb_instr", bus.instrucao, palavra(e));
          if (!desvio) exp_q.push_back(e + 8'd1);
        end
      end
      if (bus.instrucao_valida && !bus.decod_pronto)
        if (m_bolhas != 16'hFFFF) m_bolhas = m_bolhas + 1;
      if (desvio) begin
        exp_q.delete();
        exp_q.push_back(alvo_desvio);
      end
      p_hold  = bus.instrucao_valida && !bus.decod_pronto && !desvio;
      p_instr = bus.instrucao;
      p_pc    = bus.pc_instrucao;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int x0;
    reset_n          = 1'b0;
    desvio           = 1'b0;
    alvo_desvio      = 8'h00;
    bus.decod_pronto = 1'b1;
    repeat (3) tick();
    chk("rst_instr", bus.instrucao, 32'h0);
    chk("rst_pc_instr", 32'(bus.pc_instrucao), 32'h0);
    chk("rst_mem_end", 32'(bus.mem_endereco), 32'h0);
    chk("rst_valid", 32'(bus.instrucao_valida), 32'h0);
    chk("rst_leitura", 32'(bus.mem_leitura), 32'h0);

    reset_n = 1'b1;
    #1;
    chk("inicio_wr", 32'(EscrevePC), 32'd1);
    chk("inicio_val", 32'(valorEntradaPC), 32'(VR));
    tick();
    chk("busca_rd", 32'(bus.mem_leitura), 32'd1);
    chk("busca_end", 32'(bus.mem_endereco), 32'(VR));
    tick();
    chk("espera_wr", 32'(EscrevePC), 32'd1);
    chk("espera_inc", 32'(valorEntradaPC), 32'h01);
    tick();
    chk("first_valid", 32'(bus.instrucao_valida), 32'd1);
    chk("first_instr", bus.instrucao, 32'hA000_0000);
    wait_valid(n);
    chk("lat2", 32'(n), 32'd3);
    chk("instr1", bus.instrucao, 32'hA000_0001);
    wait_valid(n);
    chk("lat3", 32'(n), 32'd3);
    chk("instr2", bus.instrucao, 32'hA000_0002);

    // decoder stall for 5 cycles
    bus.decod_pronto = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_instr", bus.instrucao, 32'hA000_0002);
      chk("stall_rd", 32'(bus.mem_leitura), 32'd0);
      chk("stall_wr", 32'(EscrevePC), 32'd0);
    end
`ifdef BUSCA_PERF_EN
    chk("bolhas5", 32'(cont_bolhas), 32'd5);
`endif
    bus.decod_pronto = 1'b1;
    wait_valid(n);
    chk("lat_stall", 32'(n), 32'd3);
    chk("instr3", bus.instrucao, 32'hA000_0003);

    // redirect in ESPERA
    tick();
    chk("busca4_end", 32'(bus.mem_endereco), 32'h04);
    tick();
    desvio      = 1'b1;
    alvo_desvio = 8'h40;
    #1;
    chk("redir_wr", 32'(EscrevePC), 32'd1);
    chk("redir_val", 32'(valorEntradaPC), 32'h40);
    tick();
    desvio = 1'b0;
    chk("redir_end", 32'(bus.mem_endereco), 32'h40);
    chk("redir_novalid", 32'(bus.instrucao_valida), 32'd0);
    wait_valid(n);
    chk("lat_redir", 32'(n + 1), 32'd3);
    chk("redir_instr", bus.instrucao, 32'hA000_0040);

    // redirect in stalled SEGURA to FF, then wrap
    bus.decod_pronto = 1'b0;
    desvio           = 1'b1;
    alvo_desvio      = 8'hFF;
    #1;
    chk("redir_ff", 32'(valorEntradaPC), 32'hFF);
    tick();
    desvio           = 1'b0;
    bus.decod_pronto = 1'b1;
    tick();
    chk("wrap_inc", 32'(valorEntradaPC), 32'h00);
    tick();
    chk("ff_pc", 32'(bus.pc_instrucao), 32'hFF);
    chk("ff_instr", bus.instrucao, 32'hA000_00FF);
    wait_valid(n);
    chk("wrap_pc", 32'(bus.pc_instrucao), 32'h00);

    // redirect with accepted transfer
    x0          = n_xfer;
    desvio      = 1'b1;
    alvo_desvio = 8'h80;
    tick();
    desvio = 1'b0;
    chk("xfer_counted", 32'(n_xfer - x0), 32'd1);
`ifdef BUSCA_PERF_EN
    chk("cont_instr", 32'(cont_instrucoes), 32'(m_instr));
`endif
    wait_valid(n);
    chk("tgt80_pc", 32'(bus.pc_instrucao), 32'h80);
    chk("tgt80_instr", bus.instrucao, 32'hA000_0080);

    // async reset during ESPERA
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.instrucao_valida), 32'd0);
    chk("arst_rd", 32'(bus.mem_leitura), 32'd0);
    chk("arst_instr", bus.instrucao, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    wait_valid(n);
    chk("arst_lat", 32'(n), 32'd3);
    chk("arst_pc", 32'(bus.pc_instrucao), 32'(VR));

    // random phase
    x0 = n_xfer;
    repeat (600) begin
      bus.decod_pronto = ($urandom_range(0, 3) != 0);
      desvio           = ($urandom_range(0, 9) == 0);
      alvo_desvio      = 8'($urandom_range(0, 255));
      tick();
    end
    desvio           = 1'b0;
    bus.decod_pronto = 1'b1;
    repeat (8) tick();
    chk("rand_progress", 32'(n_xfer - x0 >= 20), 32'd1);
`ifdef BUSCA_PERF_EN
    chk("end_cont_instr", 32'(cont_instrucoes), 32'(m_instr));
    chk("end_cont_bolhas", 32'(cont_bolhas), 32'(m_bolhas));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
